// File: rtl/instruction_encoder_if.sv
// rtl/instruction_encoder_if.sv - decoded-field bundle handshake between loader and encoder
interface instruction_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [5:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_shamt;
  logic [5:0]  in_funct;
  logic [31:0] in_imm;
  logic [31:0] in_tar_add;

  modport master (
    output in_valid, in_type, in_op, in_rs, in_rt, in_rd,
           in_shamt, in_funct, in_imm, in_tar_add,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_type, in_op, in_rs, in_rt, in_rd,
           in_shamt, in_funct, in_imm, in_tar_add,
    output in_ready
  );
endinterface

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs decoded fields into 32-bit words and streams them to instruction memory
module instruction_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  instruction_encoder_if.slave bus,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                err_valid,
  output logic [2:0]          err_code,
  output logic                err_sticky,
  output logic [ADDR_W:0]     wr_count,
  output logic                full
);

  typedef enum logic [1:0] {
    TYPE_R   = 2'b00,
    TYPE_I   = 2'b01,
    TYPE_J   = 2'b10,
    TYPE_BAD = 2'b11
  } instr_type_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MISMATCH = 3'd1;
  localparam logic [2:0] ERR_IMM      = 3'd2;
  localparam logic [2:0] ERR_SHAMT    = 3'd3;
  localparam logic [2:0] ERR_TAR      = 3'd4;
  localparam logic [2:0] ERR_TYPE     = 3'd5;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  logic [31:0] word;
  logic [2:0]  code;
  logic        is_j_op;
  logic        is_logic_op;
  logic        accept;

  assign full         = (wr_count == DEPTH_C);
  assign bus.in_ready = !full && !clear;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    code        = ERR_NONE;
    word        = '0;
    is_j_op     = (bus.in_op == 6'd1) || (bus.in_op == 6'd2);
    // ORI/ANDI take a zero-extended immediate, everything else sign-extended
    is_logic_op = (bus.in_op == 6'd5) || (bus.in_op == 6'd6);
    case (bus.in_type)
      TYPE_R: begin
        word = {6'b0, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt[4:0], bus.in_funct};
        if (bus.in_op != 6'd0)
          code = ERR_MISMATCH;
        else if (|bus.in_shamt[31:5])
          code = ERR_SHAMT;
      end
      TYPE_I: begin
        word = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
        if ((bus.in_op == 6'd0) || is_j_op)
          code = ERR_MISMATCH;
        else if (is_logic_op ? (|bus.in_imm[31:16])
                             : !((&bus.in_imm[31:15]) || !(|bus.in_imm[31:15])))
          code = ERR_IMM;
      end
      TYPE_J: begin
        word = {bus.in_op, bus.in_tar_add[25:0]};
        if (!is_j_op)
          code = ERR_MISMATCH;
        else if (|bus.in_tar_add[31:26])
          code = ERR_TAR;
      end
      default: code = ERR_TYPE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      err_sticky <= 1'b0;
      wr_count   <= '0;
    end else begin
      mem_we    <= 1'b0;
      err_valid <= 1'b0;
      if (clear) begin
        wr_count <= '0;
      end else if (accept) begin
        if (code == ERR_NONE) begin
          mem_we    <= 1'b1;
          mem_addr  <= wr_count[ADDR_W-1:0];
          mem_wdata <= word;
          wr_count  <= wr_count + ONE;
          err_code  <= ERR_NONE;
        end else begin
          err_valid  <= 1'b1;
          err_code   <= code;
          err_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder
module tb_instruction_encoder;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              err_valid;
  logic [2:0]        err_code;
  logic              err_sticky;
  logic [ADDR_W:0]   wr_count;
  logic              full;

  int checks;
  int failures;

  instruction_encoder_if bus ();

  instruction_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_sticky (err_sticky),
    .wr_count   (wr_count),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [1:0] t, input logic [5:0] op,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] shamt, input logic [5:0] funct,
                            input logic [31:0] imm, input logic [31:0] tar);
    bus.in_type    = t;
    bus.in_op      = op;
    bus.in_rs      = rs;
    bus.in_rt      = rt;
    bus.in_rd      = rd;
    bus.in_shamt   = shamt;
    bus.in_funct   = funct;
    bus.in_imm     = imm;
    bus.in_tar_add = tar;
  endtask

  task automatic send_one;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] cnt);
    check({tag, "_we"}, mem_we, 1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_data"}, mem_wdata, data);
    check({tag, "_cnt"}, wr_count, cnt);
    check({tag, "_ev"}, err_valid, 0);
    check({tag, "_code"}, err_code, 0);
  endtask

  task automatic expect_reject(input string tag, input logic [31:0] code, input logic [31:0] cnt);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_ev"}, err_valid, 1);
    check({tag, "_code"}, err_code, code);
    check({tag, "_sticky"}, err_sticky, 1);
    check({tag, "_cnt"}, wr_count, cnt);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    set_fields(2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 6'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_wdata, 0);
    check("rst_ev", err_valid, 0);
    check("rst_code", err_code, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_cnt", wr_count, 0);
    check("rst_full", full, 0);
    check("rst_ready", bus.in_ready, 1);

    set_fields(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'd4, 6'h20, 32'd0, 32'd0);
    send_one();
    expect_write("r_enc", 0, 32'h0022_1920, 1);

    set_fields(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 32'd0, 6'd0, 32'hFFFF_FFFF, 32'd0);
    send_one();
    expect_write("i_sext", 1, 32'h2022_FFFF, 2);

    set_fields(2'b01, 6'd6, 5'd1, 5'd2, 5'd0, 32'd0, 6'd0, 32'hFFFF_FFFF, 32'd0);
    send_one();
    expect_reject("andi_neg", 2, 2);
    check("andi_neg_hold", mem_wdata, 32'h2022_FFFF);

    set_fields(2'b01, 6'd6, 5'd1, 5'd2, 5'd0, 32'd0, 6'd0, 32'h0000_FFFF, 32'd0);
    send_one();
    expect_write("andi_ok", 2, 32'h1822_FFFF, 3);
    check("andi_ok_sticky", err_sticky, 1);

    @(posedge clk);
    #1;
    check("idle_we", mem_we, 0);
    check("idle_addr", mem_addr, 2);

    clear = 1'b1;
    #1;
    check("clr_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_cnt", wr_count, 0);

    set_fields(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 32'd0, 6'd0, 32'd0, 32'h03FF_FFFF);
    send_one();
    expect_write("j_max", 0, 32'h0BFF_FFFF, 1);

    set_fields(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 32'd0, 6'd0, 32'd0, 32'h0400_0000);
    send_one();
    expect_reject("j_over", 4, 1);

    set_fields(2'b00, 6'd5, 5'd1, 5'd2, 5'd3, 32'd32, 6'h20, 32'd0, 32'd0);
    send_one();
    expect_reject("r_op5", 1, 1);

    set_fields(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 6'd0, 32'd0, 32'd0);
    send_one();
    expect_reject("bad_type", 5, 1);

    set_fields(2'b10, 6'h08, 5'd0, 5'd0, 5'd0, 32'd0, 6'd0, 32'd0, 32'd0);
    send_one();
    expect_reject("j_op8", 1, 1);

    set_fields(2'b01, 6'd0, 5'd1, 5'd2, 5'd0, 32'd0, 6'd0, 32'd0, 32'd0);
    send_one();
    expect_reject("i_op0", 1, 1);

    set_fields(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'd32, 6'h20, 32'd0, 32'd0);
    send_one();
    expect_reject("r_shamt", 3, 1);

    set_fields(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 32'd0, 6'd0, 32'h0000_8000, 32'd0);
    send_one();
    expect_reject("addi_8000", 2, 1);

    set_fields(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 32'd0, 6'd0, 32'h0000_7FFF, 32'd0);
    send_one();
    expect_write("addi_7fff", 1, 32'h2022_7FFF, 2);
    check("addi_7fff_sticky", err_sticky, 1);

    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;

    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fields(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 6'(i), 32'd0, 32'd0);
      @(posedge clk);
      #1;
      expect_write($sformatf("fill%0d", i), i, 32'h0022_1800 + i, i + 1);
    end
    check("fill_full", full, 1);
    check("fill_ready", bus.in_ready, 0);
    set_fields(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 6'd4, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check("fill5_we", mem_we, 0);
    check("fill5_cnt", wr_count, 4);
    check("fill5_addr", mem_addr, 3);

    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clrv_we", mem_we, 0);
    check("clrv_cnt", wr_count, 0);
    check("clrv_full", full, 0);
    set_fields(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 6'd9, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    expect_write("post_clr", 0, 32'h0022_1809, 1);

    set_fields(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 6'd10, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    expect_write("pre_rst", 1, 32'h0022_180A, 2);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst_we", mem_we, 0);
    check("mrst_addr", mem_addr, 0);
    check("mrst_data", mem_wdata, 0);
    check("mrst_ev", err_valid, 0);
    check("mrst_code", err_code, 0);
    check("mrst_sticky", err_sticky, 0);
    check("mrst_cnt", wr_count, 0);
    check("mrst_full", full, 0);

    set_fields(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 6'd11, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expect_write("post_rst", 0, 32'h0022_180B, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded instruction fields back into 32-bit instruction words and streams them into instruction memory. This is the writer-side counterpart of the instruction decoder: it checks that the type and opcode agree and that every field fits its encoding, writes legal words to consecutive addresses, and reports illegal ones. It sits between the program loader/testbench front end and the instruction-memory write port.

## Interface
- `ADDR_W`, 8: instruction-memory address width.
- `DEPTH`, 256: maximum words written before `full`; must be ≤ 2^ADDR_W.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `clear`  in  1  synchronous pointer/counter clear; does not affect `err_sticky`.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  combinational: `!full && !clear`.
- `in_type`  in  2  00 R, 01 I, 10 J, 11 illegal.
- `in_op`  in  6  opcode.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields.
- `in_shamt`  in  32  shift amount, zero-extended form.
- `in_funct`  in  6  function code.
- `in_imm`  in  32  immediate, extended form.
- `in_tar_add`  in  32  jump target, zero-extended form.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  32  encoded word.
- `err_valid`  out  1  one-cycle reject pulse.
- `err_code`  out  3  reason; held until the next accepted bundle.
- `err_sticky`  out  1  set on any reject; cleared only by reset.
- `wr_count`  out  ADDR_W+1  words written since reset or clear.
- `full`  out  1  `wr_count == DEPTH`.

## Operation
- Accept on a rising edge where `in_valid && in_ready`. If `in_ready` is low, `in_valid` is ignored.
- Encoding:
  - R type: `{6'b0, rs, rt, rd, shamt[4:0], funct}`.
  - I type: `{op, rs, rt, imm[15:0]}`.
  - J type: `{op, tar_add[25:0]}`.
  - Fields unused by a type are ignored.
- Checks, first match wins:
  1. `type == 11`: code 5.
  2. Type/opcode mismatch: code 1. The required pairings are R with op=0, J with op ∈ {1, 2}, and I with any other op.
  3. Out-of-range field: code 2 for `imm`, 3 for `shamt`, 4 for `tar_add`.
     - `imm` for op 5 (ORI) or op 6 (ANDI) must satisfy `imm[31:16] == 0`.
     - `imm` for every other I-type op must have `imm[31:15]` all equal (sign-extension form).
     - R type requires `shamt[31:5] == 0`.
     - J type requires `tar_add[31:26] == 0`.
- Legal bundle: register `mem_we = 1`, `mem_addr = wr_count[ADDR_W-1:0]`, `mem_wdata = word`, `wr_count += 1`, `err_code = 0`.
- Illegal bundle: register `mem_we = 0`, `err_valid = 1`, `err_code = reason`, `err_sticky = 1`. `wr_count` is unchanged. A rejected bundle still counts as consumed.
- `clear`: `wr_count <= 0`, `mem_we <= 0`, `err_valid <= 0`. Because `in_ready` is low during `clear`, `clear` wins over `in_valid` in the same cycle.
- `wr_count` never wraps. Once it reaches `DEPTH`, `full` holds it there until `clear` or reset.

## Timing
- Reset (`rst_n` low at an edge) forces, at that edge:
  - `mem_we`, `mem_addr`, `mem_wdata` = 0
  - `err_valid`, `err_code`, `err_sticky` = 0
  - `wr_count` = 0, therefore `full` = 0
- Reset mid-stream discards any bundle presented in that cycle.
- Latency is 1 cycle: a bundle accepted at edge N appears on the `mem_*` or `err_*` outputs during cycle N+1.
- `mem_we` and `err_valid` are single-cycle pulses. They fall at the next edge unless another bundle is accepted there.
- Back-to-back accepts give one bundle per cycle and consecutive addresses.
- `full` rises in the cycle after the DEPTH-th write, so `in_ready` drops in that same cycle. No stall bubble occurs before that point.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we` is 0.

## Test plan
- R encode: type=00, op=0, rs=1, rt=2, rd=3, shamt=4, funct=0x20 → next cycle `mem_we=1`, `mem_addr=0`, `mem_wdata=0x00221920`, `wr_count=1`.
- I sign/zero extension:
  - op=0x08, rs=1, rt=2, imm=0xFFFFFFFF → `0x2022FFFF`.
  - op=6, imm=0xFFFFFFFF → `err_valid=1`, `err_code=2`, no write.
  - op=6, imm=0x0000FFFF → `0x1822FFFF`.
- J range: op=2, tar_add=0x03FFFFFF → `0x0BFFFFFF`. Then tar_add=0x04000000 → `err_code=4`, `wr_count` unchanged.
- Mismatch and illegal type:
  - type=R, op=5 → `err_code=1`.
  - type=11 → `err_code=5`.
  - `err_sticky` stays 1 through later good writes.
- Fill and clear (DEPTH=4): 5 back-to-back valid bundles → writes to addresses 0–3, `full=1`, `in_ready=0`, 5th not consumed. Assert `clear` together with `in_valid` → no write, `wr_count=0`. The next bundle writes to address 0.
- Reset mid-stream: drop `rst_n` while `in_valid=1` after 2 writes → all outputs 0 at the next edge, `err_sticky=0`. The first post-reset write goes to address 0.
